// File: rtl/instr_encoder_loader.sv
// Encodes decoded ARM instruction fields (DP, LDR/STR, B/BL) into 32-bit words and streams them
// into the instruction-memory write port. Optional running XOR checksum under `ENC_CHECKSUM_EN.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        cls,
  input  logic [3:0]        cond,
  input  logic [3:0]        cmd,
  input  logic              s_bit,
  input  logic              imm_sel,
  input  logic              load,
  input  logic              up,
  input  logic              link,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [3:0]        rm,
  input  logic [11:0]       imm12,
  input  logic [23:0]       imm24,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W-1:0] word_cnt,
  output logic [7:0]        err_cnt,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [11:0]       op2;
  logic [31:0]       enc;
  logic              legal;
  logic              accept;
  logic              wr;
  logic              end_session;
  logic              new_session;

  // NOTE: every output of a combinational block gets a default first so no path leaves it
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    enc = 32'h0;
    op2 = imm_sel ? imm12 : {8'h00, rm};
    unique case (cls)
      2'b00:   enc = {cond, 2'b00, imm_sel, cmd, s_bit, rn, rd, op2};
      2'b01:   enc = {cond, 2'b01, ~imm_sel, 1'b1, up, 1'b0, 1'b0, load, rn, rd, op2};
      2'b10:   enc = {cond, 3'b101, link, imm24};
      default: enc = 32'h0;
    endcase
  end

  assign legal       = (cls != 2'b11);
  assign in_ready    = (state == S_LOAD) && !clr;
  assign accept      = in_valid && in_ready;
  assign wr          = accept && legal;
  // A session closes on the flagged last bundle (legal or not) or on the DEPTH-th legal word.
  assign end_session = accept && (in_last || (legal && (word_cnt == LAST_IDX)));
  assign new_session = start && (state != S_LOAD);

  // NOTE: sequential state is updated with non-blocking assignments only, so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else if (clr) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (start) state <= S_LOAD;
        S_LOAD:  if (end_session) state <= S_DONE;
        S_DONE:  if (start) state <= S_LOAD;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
      wr_ptr     <= BASE;
      word_cnt   <= '0;
      err_cnt    <= 8'h00;
    end else if (clr) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
      wr_ptr     <= BASE;
      word_cnt   <= '0;
      err_cnt    <= 8'h00;
    end else begin
      imem_we <= wr;
      if (new_session) begin
        wr_ptr   <= BASE;
        word_cnt <= '0;
        err_cnt  <= 8'h00;
      end
      if (wr) begin
        imem_addr  <= wr_ptr;
        imem_wdata <= enc;
        wr_ptr     <= wr_ptr + ADDR_W'(4);
        word_cnt   <= word_cnt + ADDR_W'(1);
      end
      if (accept && !legal && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'h01;
      end
    end
  end

  assign busy = (state == S_LOAD);
  assign done = (state == S_DONE);

`ifdef ENC_CHECKSUM_EN
  logic [31:0] sum_q;

  // Folded in at accept time so the checksum moves in the same cycle as the imem_we pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= 32'h0;
    end else if (clr || new_session) begin
      sum_q <= 32'h0;
    end else if (wr) begin
      sum_q <= sum_q ^ enc;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: directed program load, full/error/abort cases,
// then randomized sessions against a field-level encoding model.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 8;
  localparam int BASE   = 16;

  typedef struct {
    logic [1:0]  cls;
    logic [3:0]  cond, cmd, rn, rd, rm;
    logic        s_bit, imm_sel, load, up, link, last;
    logic [11:0] imm12;
    logic [23:0] imm24;
  } bundle_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start, clr, in_valid, in_ready, in_last;
  logic [1:0]        cls;
  logic [3:0]        cond, cmd, rn, rd, rm;
  logic              s_bit, imm_sel, load, up, link;
  logic [11:0]       imm12;
  logic [23:0]       imm24;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W-1:0] word_cnt;
  logic [7:0]        err_cnt;
  logic              busy, done;
  logic [31:0]       checksum;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .cls(cls), .cond(cond), .cmd(cmd), .s_bit(s_bit), .imm_sel(imm_sel),
    .load(load), .up(up), .link(link), .rn(rn), .rd(rd), .rm(rm),
    .imm12(imm12), .imm24(imm24),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .word_cnt(word_cnt), .err_cnt(err_cnt), .busy(busy), .done(done),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  wr_t         exp_q[$];
  logic [31:0] wlog[$];
  int          wcyc[$];

  // Reference state of the loader as seen by a program author.
  bit          m_load, m_done;
  int          m_cnt, m_err;
  logic [31:0] m_sum;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_enc(input bundle_t b);
    logic [31:0] op2;
    op2 = b.imm_sel ? 32'(b.imm12) : 32'(b.rm);
    case (b.cls)
      2'b00: return (32'(b.cond) << 28) | (32'(b.imm_sel) << 25) | (32'(b.cmd) << 21) |
                    (32'(b.s_bit) << 20) | (32'(b.rn) << 16) | (32'(b.rd) << 12) | op2;
      2'b01: return (32'(b.cond) << 28) | (32'd1 << 26) | (32'(!b.imm_sel) << 25) | (32'd1 << 24) |
                    (32'(b.up) << 23) | (32'(b.load) << 20) | (32'(b.rn) << 16) |
                    (32'(b.rd) << 12) | op2;
      2'b10: return (32'(b.cond) << 28) | (32'd5 << 25) | (32'(b.link) << 24) | 32'(b.imm24);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bundle_t zero_bundle();
    bundle_t b;
    b = '{cls: 2'b00, cond: 4'hE, cmd: 4'h0, rn: 4'h0, rd: 4'h0, rm: 4'h0, s_bit: 1'b0,
          imm_sel: 1'b0, load: 1'b0, up: 1'b0, link: 1'b0, last: 1'b0, imm12: 12'h0, imm24: 24'h0};
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b = zero_bundle();
    b.cls     = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    b.cond    = 4'($urandom);
    b.cmd     = 4'($urandom);
    b.rn      = 4'($urandom);
    b.rd      = 4'($urandom);
    b.rm      = 4'($urandom);
    b.s_bit   = 1'($urandom);
    b.imm_sel = 1'($urandom);
    b.load    = 1'($urandom);
    b.up      = 1'($urandom);
    b.link    = 1'($urandom);
    b.last    = ($urandom_range(0, 9) == 0);
    b.imm12   = 12'($urandom);
    b.imm24   = 24'($urandom);
    return b;
  endfunction

  task automatic model_accept(input bundle_t b);
    wr_t w;
    if (b.cls != 2'b11) begin
      w.addr = ADDR_W'(BASE + 4 * m_cnt);
      w.data = model_enc(b);
      exp_q.push_back(w);
      m_sum ^= w.data;
      m_cnt++;
    end else if (m_err < 255) begin
      m_err++;
    end
    if (b.last || m_cnt == DEPTH) begin
      m_load = 0;
      m_done = 1;
    end
  endtask

  // Offer a bundle for up to `budget` cycles; called and returns at posedge+1.
  task automatic offer(input bundle_t b, input int budget, output bit acc);
    cls = b.cls; cond = b.cond; cmd = b.cmd; rn = b.rn; rd = b.rd; rm = b.rm;
    s_bit = b.s_bit; imm_sel = b.imm_sel; load = b.load; up = b.up; link = b.link;
    imm12 = b.imm12; imm24 = b.imm24; in_last = b.last;
    in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        model_accept(b);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!m_load) begin
      m_load = 1; m_done = 0; m_cnt = 0; m_err = 0; m_sum = 32'h0;
    end
  endtask

  task automatic model_clear();
    m_load = 0; m_done = 0; m_cnt = 0; m_err = 0; m_sum = 32'h0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_clear();
  endtask

  task automatic check_status(input string tag);
    check({tag, ".busy"}, busy, m_load);
    check({tag, ".done"}, done, m_done);
    check({tag, ".word_cnt"}, word_cnt, m_cnt);
    check({tag, ".err_cnt"}, err_cnt, m_err);
    check({tag, ".in_ready"}, in_ready, m_load);
`ifdef ENC_CHECKSUM_EN
    check({tag, ".checksum"}, checksum, m_sum);
`else
    check({tag, ".checksum"}, checksum, 32'h0);
`endif
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", 32'(imem_addr), 32'hFFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          check("wr_addr", 32'(imem_addr), 32'(w.addr));
          check("wr_data", imem_wdata, w.data);
        end
        wlog.push_back(imem_wdata);
        wcyc.push_back(cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bundle_t b;
    bit acc;
    int n;

    reset_n = 1'b0; start = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    b = zero_bundle();
    cls = 2'b00; cond = 4'h0; cmd = 4'h0; rn = 4'h0; rd = 4'h0; rm = 4'h0;
    s_bit = 1'b0; imm_sel = 1'b0; load = 1'b0; up = 1'b0; link = 1'b0;
    imm12 = 12'h0; imm24 = 24'h0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst.imem_we", imem_we, 0);
    check("rst.imem_addr", imem_addr, 0);
    check("rst.imem_wdata", imem_wdata, 0);
    check_status("rst");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed program: two DP, two MEM, one terminating branch, all back-to-back.
    do_start();
    b = zero_bundle(); b.cmd = 4'b0100; b.imm_sel = 1; b.rn = 2; b.rd = 1; b.imm12 = 12'h005;
    offer(b, 4, acc);
    b = zero_bundle(); b.cmd = 4'b0010; b.s_bit = 1; b.rm = 1;
    offer(b, 4, acc);
`ifdef ENC_CHECKSUM_EN
    check("dir.checksum_pair", checksum, 32'h02D2_1004);
`endif
    b = zero_bundle(); b.cls = 2'b01; b.load = 1; b.up = 1; b.imm_sel = 1; b.rn = 4; b.rd = 3;
    b.imm12 = 12'h008;
    offer(b, 4, acc);
    b.load = 0; b.up = 0;
    offer(b, 4, acc);
    b = zero_bundle(); b.cls = 2'b10; b.cond = 4'h1; b.imm24 = 24'hFFFFFE; b.last = 1;
    offer(b, 4, acc);
    check_status("dir.end");
    repeat (2) @(posedge clk);
    #1;
    check("dir.nwrites", wlog.size(), 5);
    if (wlog.size() == 5) begin
      check("dir.w0", wlog[0], 32'hE282_1005);
      check("dir.w1", wlog[1], 32'hE050_0001);
      check("dir.w2", wlog[2], 32'hE594_3008);
      check("dir.w3", wlog[3], 32'hE504_3008);
      check("dir.w4", wlog[4], 32'h1AFF_FFFE);
      check("dir.back_to_back", wcyc[1] - wcyc[0], 1);
    end

    // Fill to DEPTH: the extra bundle must not be taken.
    do_start();
    for (int i = 0; i < DEPTH; i++) begin
      b = rand_bundle(); b.cls = 2'($urandom_range(0, 2)); b.last = 0;
      offer(b, 4, acc);
      check("full.accept", acc, 1);
    end
    b = rand_bundle(); b.cls = 2'b00; b.last = 0;
    offer(b, 4, acc);
    check("full.extra_rejected", acc, 0);
    check_status("full");

    // Illegal class consumed without a write.
    do_start();
    b = rand_bundle(); b.cls = 2'b11; b.last = 0;
    offer(b, 4, acc);
    check_status("illegal");

    // clr coincident with a valid bundle: nothing accepted, back to idle.
    b = rand_bundle(); b.cls = 2'b00;
    cls = b.cls; in_valid = 1'b1; clr = 1'b1;
    @(negedge clk);
    check("clr.in_ready", in_ready, 0);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    model_clear();
    check_status("clr_accept");

    // clr in the middle of a session.
    do_start();
    for (int i = 0; i < 3; i++) begin
      b = rand_bundle(); b.last = 0;
      offer(b, 4, acc);
    end
    do_clr();
    @(posedge clk); #1;
    check_status("clr_mid");

    // err_cnt saturation.
    do_start();
    for (int i = 0; i < 260; i++) begin
      b = rand_bundle(); b.cls = 2'b11; b.last = 0;
      offer(b, 4, acc);
    end
    check_status("err_sat");
    do_clr();

    // Randomized sessions with gaps, stray starts and occasional aborts.
    for (int s = 0; s < 25; s++) begin
      do_start();
      n = 0;
      while (m_load && n < DEPTH + 4) begin
        b = rand_bundle();
        offer(b, 4, acc);
        n++;
        if ($urandom_range(0, 19) == 0) do_start();
        if ($urandom_range(0, 39) == 0) do_clr();
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      check_status("rand");
      if ($urandom_range(0, 3) == 0) do_clr();
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
